program_sequencer: RTL and testbench
====================================

Name: program_sequencer

Overview:
- Controller between the front-panel instruction assembler and the instruction memory.
- Load mode (prog=1): captures each assembled 32-bit instruction on a store strobe and writes it to consecutive memory addresses.
- Run mode (prog=0): fetches and executes the stored program against an internal 4x16 register file.
- Exposes PC, state and the register selected by reg_sel for the display path.

Parameters:
ADDR_W, 4, instruction memory address width; DEPTH = 2^ADDR_W entries
DATA_W, 16, register and immediate width (fixed at 16 by the instruction format)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
prog  input  1  1 = load mode, 0 = run mode
inst  input  32  assembled instruction: [15:0] value, [17:16] dest, [21:20] src, [26:24] opcode
store_clk  input  1  store strobe from assembler; level signal, rising edge = one store
imem_addr  output  ADDR_W  instruction memory address
imem_wdata  output  32  instruction memory write data
imem_we  output  1  instruction memory write enable, one-cycle pulse
imem_rdata  input  32  memory read data, valid 1 cycle after imem_addr
reg_sel  input  2  display register select
reg_out  output  16  R[reg_sel], combinational
pc  output  ADDR_W  program counter
prog_len  output  ADDR_W+1  number of stored instructions, 0..DEPTH
state  output  3  IDLE=0, LOAD=1, FETCH=2, WAIT=3, EXEC=4, HALT=5
halted  output  1  1 while in HALT
load_full  output  1  sticky; set when a store is attempted with prog_len==DEPTH
err_op  output  1  sticky; set on an undefined opcode

Behaviour:
- Reset: state=IDLE; pc, prog_len, IR, R0..R3 = 0; imem_we, halted, load_full, err_op = 0; imem_addr and imem_wdata = 0.
- Store edge detection: store_d <= store_clk every cycle; store_evt = store_clk & ~store_d.
  - store_evt is acted on only while state==LOAD.
  - A store_clk held high for N cycles produces exactly one store.
- IDLE:
  - prog=1 -> LOAD; prog_len <= 0; load_full <= 0.
  - prog=0 and prog_len>0 -> FETCH with pc <= 0.
  - Otherwise stay in IDLE.
- LOAD:
  - On store_evt with prog_len<DEPTH: next cycle imem_we=1, imem_addr=prog_len[ADDR_W-1:0], imem_wdata=inst captured at the store_evt cycle; prog_len increments at the end of that write cycle.
  - On store_evt with prog_len==DEPTH: no write, load_full <= 1.
  - prog falls: -> FETCH with pc <= 0 if prog_len>0, else -> IDLE.
  - A pending write completes before the state leaves LOAD.
- FETCH: imem_addr=pc; -> WAIT.
- WAIT: IR <= imem_rdata; -> EXEC.
- EXEC, decode IR[26:24]:
  - 0 (add): R[dest] <= R[src] + value, mod 2^16 (0xFFFF+1=0x0000); pc <= pc+1. dest==src is allowed.
  - 7 (jump): pc <= value[ADDR_W-1:0]; value upper bits are ignored.
  - 1..6: no register write, pc <= pc+1, err_op <= 1.
  - Next state: prog=1 -> LOAD (the EXEC register write still occurs). Else if the new pc >= prog_len -> HALT. Else -> FETCH.
- Each instruction takes exactly 3 cycles (FETCH, WAIT, EXEC).
- prog rising during FETCH or WAIT: -> LOAD immediately; no register write, pc unchanged.
- HALT: halted=1, pc holds; prog=1 -> LOAD; otherwise stay in HALT.
- Register file keeps its contents across LOAD and run cycles; only reset clears it.
- imem_we is never asserted outside LOAD.
- pc arithmetic wraps at DEPTH. The halt check compares against prog_len, so the wrap only matters when prog_len==DEPTH.
- Reset asserted in any state, including mid-write or mid-EXEC: reset values on the next edge; the in-flight write or register update is dropped.

Test Plan:
- Load three instructions (add R1=R0+0x0005; add R2=R1+0x0010; add R1=R1+0xFFFF), then drop prog -> three single-cycle imem_we pulses at addresses 0,1,2; prog_len=3; after run R1=0x0004, R2=0x0015; halted=1 exactly 9 cycles after first FETCH.
- Hold store_clk high for 10 cycles in LOAD -> exactly one imem_we pulse; prog_len increments by 1.
- Program (add R0=R0+1; jump 0) -> R0 increments every 6 cycles, never halts; raise prog during WAIT -> state=LOAD next cycle, R0 unchanged afterwards.
- ADDR_W=4, issue 17 store edges -> 16 writes at addresses 0..15; 17th produces no imem_we; load_full=1; prog_len=16.
- Opcode 3 at address 0, jump to 9 at address 1, prog_len=2 -> err_op=1, no register changes, HALT after the jump with pc=9; add R3=R3+1 from R3=0xFFFF gives 0x0000.
- Assert reset for one cycle during EXEC of an add -> state=IDLE, pc=0, prog_len=0, all registers 0, all flags 0; the add result is not written.

Source files
------------

// File: rtl/program_sequencer_if.sv
// Instruction-memory bus between program_sequencer and the instruction memory.
//   imem_addr  : word address (write address in LOAD, fetch address in FETCH)
//   imem_wdata : write data
//   imem_we    : one-cycle write strobe
//   imem_rdata : read data, valid one cycle after imem_addr
// master = sequencer side, slave = memory side.
interface program_sequencer_if #(
  parameter int unsigned ADDR_W = 4
) ();
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_we;
  logic [31:0]       imem_rdata;

  modport master (
    output imem_addr,
    output imem_wdata,
    output imem_we,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    input  imem_wdata,
    input  imem_we,
    output imem_rdata
  );
endinterface

// File: rtl/program_sequencer.sv
// program_sequencer: loads assembled instructions into instruction memory (prog=1) and
// runs the stored program against a 4x16 register file (prog=0).
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   prog            : 1 = load mode, 0 = run mode
//   inst            : assembled instruction {5'b0, op[2:0], 2'b0, src, 2'b0, dest, value[15:0]}
//   store_clk       : store strobe level; each rising edge stores one instruction
//   imem            : instruction memory bus (master side)
//   reg_sel/reg_out : display read port, reg_out = R[reg_sel]
//   pc, prog_len    : program counter, number of stored instructions (0..DEPTH)
//   state, halted   : FSM state code, HALT indicator
//   load_full       : sticky, store attempted with memory full
//   err_op          : sticky, undefined opcode executed
module program_sequencer #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                prog,
  input  logic [31:0]         inst,
  input  logic                store_clk,
  program_sequencer_if.master imem,
  input  logic [1:0]          reg_sel,
  output logic [DATA_W-1:0]   reg_out,
  output logic [ADDR_W-1:0]   pc,
  output logic [ADDR_W:0]     prog_len,
  output logic [2:0]          state,
  output logic                halted,
  output logic                load_full,
  output logic                err_op
);

  localparam logic [ADDR_W:0] DepthL = (ADDR_W + 1)'(1 << ADDR_W);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StFetch = 3'd2,
    StWait  = 3'd3,
    StExec  = 3'd4,
    StHalt  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W:0]     prog_len_q, prog_len_d;
  logic [31:0]         ir_q, ir_d;
  logic [DATA_W-1:0]   regs_q [4];
  logic [DATA_W-1:0]   regs_d [4];
  logic                store_q;
  logic                we_q, we_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                load_full_q, load_full_d;
  logic                err_op_q, err_op_d;

  logic                store_evt;
  logic [2:0]          ir_op;
  logic [1:0]          ir_dest, ir_src;
  logic [DATA_W-1:0]   ir_val;
  logic [ADDR_W-1:0]   pc_next;
  logic                unused_ir;

  assign store_evt = store_clk & ~store_q;

  assign ir_op     = ir_q[26:24];
  assign ir_src    = ir_q[21:20];
  assign ir_dest   = ir_q[17:16];
  assign ir_val    = ir_q[DATA_W-1:0];
  assign unused_ir = ^{ir_q[31:27], ir_q[23:22], ir_q[19:18]};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    prog_len_d  = prog_len_q;
    ir_d        = ir_q;
    regs_d      = regs_q;
    we_d        = 1'b0;
    wdata_d     = wdata_q;
    load_full_d = load_full_q;
    err_op_d    = err_op_q;
    pc_next     = pc_q;

    unique case (state_q)
      StIdle: begin
        if (prog) begin
          state_d     = StLoad;
          prog_len_d  = '0;
          load_full_d = 1'b0;
        end else if (prog_len_q != '0) begin
          state_d = StFetch;
          pc_d    = '0;
        end
      end

      StLoad: begin
        // Count the word at the end of its write cycle so the address stays stable.
        if (we_q) begin
          prog_len_d = prog_len_q + (ADDR_W + 1)'(1);
        end
        if (store_evt) begin
          if (prog_len_q != DepthL) begin
            we_d    = 1'b1;
            wdata_d = inst;
          end else begin
            load_full_d = 1'b1;
          end
        end
        // Stay until any accepted or in-flight write has finished.
        if (!prog && !we_q && !we_d) begin
          if (prog_len_q != '0) begin
            state_d = StFetch;
            pc_d    = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end

      StFetch: begin
        state_d = prog ? StLoad : StWait;
      end

      StWait: begin
        if (prog) begin
          state_d = StLoad;
        end else begin
          ir_d    = imem.imem_rdata;
          state_d = StExec;
        end
      end

      StExec: begin
        unique case (ir_op)
          3'd0: begin
            regs_d[ir_dest] = regs_q[ir_src] + ir_val;
            pc_next         = pc_q + ADDR_W'(1);
          end
          3'd7: begin
            pc_next = ir_val[ADDR_W-1:0];
          end
          default: begin
            pc_next  = pc_q + ADDR_W'(1);
            err_op_d = 1'b1;
          end
        endcase
        pc_d = pc_next;
        if (prog) begin
          state_d = StLoad;
        end else if ({1'b0, pc_next} >= prog_len_q) begin
          state_d = StHalt;
        end else begin
          state_d = StFetch;
        end
      end

      StHalt: begin
        if (prog) begin
          state_d = StLoad;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      prog_len_q  <= '0;
      ir_q        <= '0;
      regs_q      <= '{default: '0};
      store_q     <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      load_full_q <= 1'b0;
      err_op_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      prog_len_q  <= prog_len_d;
      ir_q        <= ir_d;
      regs_q      <= regs_d;
      store_q     <= store_clk;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      load_full_q <= load_full_d;
      err_op_q    <= err_op_d;
    end
  end

  always_comb begin
    imem.imem_addr = '0;
    if (state_q == StFetch) begin
      imem.imem_addr = pc_q;
    end else if (we_q) begin
      imem.imem_addr = prog_len_q[ADDR_W-1:0];
    end
  end

  assign imem.imem_we    = we_q;
  assign imem.imem_wdata = wdata_q;

  assign reg_out   = regs_q[reg_sel];
  assign pc        = pc_q;
  assign prog_len  = prog_len_q;
  assign state     = state_q;
  assign halted    = (state_q == StHalt);
  assign load_full = load_full_q;
  assign err_op    = err_op_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer with a behavioural instruction memory.
module tb_program_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        prog;
  logic [31:0] inst;
  logic        store_clk;
  logic [1:0]  reg_sel;
  logic [15:0] reg_out;
  logic [3:0]  pc;
  logic [4:0]  prog_len;
  logic [2:0]  state;
  logic        halted;
  logic        load_full;
  logic        err_op;

  int n_vec = 0;
  int n_err = 0;

  program_sequencer_if #(.ADDR_W(4)) bus ();

  program_sequencer #(.ADDR_W(4), .DATA_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .prog      (prog),
    .inst      (inst),
    .store_clk (store_clk),
    .imem      (bus),
    .reg_sel   (reg_sel),
    .reg_out   (reg_out),
    .pc        (pc),
    .prog_len  (prog_len),
    .state     (state),
    .halted    (halted),
    .load_full (load_full),
    .err_op    (err_op)
  );

  always #5 clk = ~clk;

  // Memory model and write monitor.
  logic [31:0] mem [16];
  logic [3:0]  we_addr [$];
  logic [31:0] we_data [$];

  always @(posedge clk) begin
    if (bus.imem_we) begin
      mem[bus.imem_addr] <= bus.imem_wdata;
      we_addr.push_back(bus.imem_addr);
      we_data.push_back(bus.imem_wdata);
    end
    bus.imem_rdata <= mem[bus.imem_addr];
  end

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [1:0] dest,
                                     input logic [1:0] src, input logic [15:0] val);
    return {5'b0, op, 2'b0, src, 2'b0, dest, val};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic get_reg(input logic [1:0] s, output logic [15:0] v);
    reg_sel = s;
    #1;
    v = reg_out;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    prog      = 1'b0;
    store_clk = 1'b0;
    inst      = '0;
    tick();
    reset = 1'b0;
    we_addr.delete();
    we_data.delete();
  endtask

  task automatic store_word(input logic [31:0] w);
    inst      = w;
    store_clk = 1'b1;
    tick();
    store_clk = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    logic [15:0] v;
    do_reset();
    n_vec++;
    if (state !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", state); end
    n_vec++;
    if (pc !== 4'd0 || prog_len !== 5'd0) begin
      n_err++; $display("FAIL reset_pc_len got pc=%0d len=%0d exp 0 0", pc, prog_len);
    end
    n_vec++;
    if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== 37'd0) begin
      n_err++;
      $display("FAIL reset_bus got we=%b addr=%h wdata=%h exp 0", bus.imem_we, bus.imem_addr,
               bus.imem_wdata);
    end
    n_vec++;
    if ({halted, load_full, err_op} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags got %b exp 000", {halted, load_full, err_op});
    end
    for (int r = 0; r < 4; r++) begin
      get_reg(2'(r), v);
      n_vec++;
      if (v !== 16'h0000) begin n_err++; $display("FAIL reset_R%0d got %h exp 0000", r, v); end
    end
  endtask

  task automatic test_load_run();
    logic [15:0] v;
    logic [31:0] exp_w [3];
    exp_w[0] = mk(3'd0, 2'd1, 2'd0, 16'h0005);
    exp_w[1] = mk(3'd0, 2'd2, 2'd1, 16'h0010);
    exp_w[2] = mk(3'd0, 2'd1, 2'd1, 16'hFFFF);
    do_reset();
    prog = 1'b1;
    tick();
    n_vec++;
    if (state !== 3'd1) begin n_err++; $display("FAIL lr_enter_load got %0d exp 1", state); end
    for (int i = 0; i < 3; i++) store_word(exp_w[i]);
    n_vec++;
    if (we_addr.size() !== 3) begin
      n_err++; $display("FAIL lr_we_count got %0d exp 3", we_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (we_addr[i] !== 4'(i) || we_data[i] !== exp_w[i]) begin
          n_err++;
          $display("FAIL lr_write%0d got addr=%0d data=%h exp addr=%0d data=%h", i, we_addr[i],
                   we_data[i], i, exp_w[i]);
        end
      end
    end
    n_vec++;
    if (prog_len !== 5'd3) begin n_err++; $display("FAIL lr_len got %0d exp 3", prog_len); end
    prog = 1'b0;
    tick();
    n_vec++;
    if (state !== 3'd2) begin n_err++; $display("FAIL lr_first_fetch got %0d exp 2", state); end
    tick(8);
    n_vec++;
    if (state !== 3'd4 || halted !== 1'b0) begin
      n_err++; $display("FAIL lr_pre_halt got state=%0d halted=%b exp 4 0", state, halted);
    end
    tick();
    n_vec++;
    if (state !== 3'd5 || halted !== 1'b1 || pc !== 4'd3) begin
      n_err++;
      $display("FAIL lr_halt got state=%0d halted=%b pc=%0d exp 5 1 3", state, halted, pc);
    end
    get_reg(2'd1, v);
    n_vec++;
    if (v !== 16'h0004) begin n_err++; $display("FAIL lr_R1 got %h exp 0004", v); end
    get_reg(2'd2, v);
    n_vec++;
    if (v !== 16'h0015) begin n_err++; $display("FAIL lr_R2 got %h exp 0015", v); end
    get_reg(2'd0, v);
    n_vec++;
    if (v !== 16'h0000) begin n_err++; $display("FAIL lr_R0 got %h exp 0000", v); end
  endtask

  task automatic test_store_hold();
    do_reset();
    prog = 1'b1;
    tick();
    inst      = mk(3'd0, 2'd0, 2'd0, 16'h1234);
    store_clk = 1'b1;
    tick(10);
    store_clk = 1'b0;
    tick();
    n_vec++;
    if (we_addr.size() !== 1) begin
      n_err++; $display("FAIL hold_we_count got %0d exp 1", we_addr.size());
    end
    n_vec++;
    if (prog_len !== 5'd1) begin n_err++; $display("FAIL hold_len got %0d exp 1", prog_len); end
  endtask

  task automatic test_jump_loop();
    logic [15:0] v;
    do_reset();
    prog = 1'b1;
    tick();
    store_word(mk(3'd0, 2'd0, 2'd0, 16'h0001));
    store_word(mk(3'd7, 2'd0, 2'd0, 16'h0000));
    prog = 1'b0;
    tick();
    tick(3);
    get_reg(2'd0, v);
    n_vec++;
    if (v !== 16'h0001) begin n_err++; $display("FAIL loop_R0_first got %h exp 0001", v); end
    tick(6);
    get_reg(2'd0, v);
    n_vec++;
    if (v !== 16'h0002 || state !== 3'd2) begin
      n_err++; $display("FAIL loop_R0_second got R0=%h state=%0d exp 0002 2", v, state);
    end
    tick();
    n_vec++;
    if (state !== 3'd3) begin n_err++; $display("FAIL loop_wait got %0d exp 3", state); end
    prog = 1'b1;
    tick();
    n_vec++;
    if (state !== 3'd1 || pc !== 4'd1) begin
      n_err++; $display("FAIL loop_abort got state=%0d pc=%0d exp 1 1", state, pc);
    end
    tick(5);
    get_reg(2'd0, v);
    n_vec++;
    if (v !== 16'h0002) begin n_err++; $display("FAIL loop_R0_hold got %h exp 0002", v); end
  endtask

  task automatic test_load_full();
    do_reset();
    prog = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) store_word(mk(3'd0, 2'd0, 2'd0, 16'(i)));
    n_vec++;
    if (load_full !== 1'b0 || prog_len !== 5'd16) begin
      n_err++; $display("FAIL full_before got lf=%b len=%0d exp 0 16", load_full, prog_len);
    end
    store_word(mk(3'd0, 2'd0, 2'd0, 16'h00AA));
    n_vec++;
    if (we_addr.size() !== 16) begin
      n_err++; $display("FAIL full_we_count got %0d exp 16", we_addr.size());
    end else begin
      n_vec++;
      if (we_addr[15] !== 4'd15 || we_data[15] !== mk(3'd0, 2'd0, 2'd0, 16'h000F)) begin
        n_err++;
        $display("FAIL full_last got addr=%0d data=%h exp 15 %h", we_addr[15], we_data[15],
                 mk(3'd0, 2'd0, 2'd0, 16'h000F));
      end
    end
    n_vec++;
    if (load_full !== 1'b1 || prog_len !== 5'd16) begin
      n_err++; $display("FAIL full_after got lf=%b len=%0d exp 1 16", load_full, prog_len);
    end
  endtask

  task automatic test_err_jump();
    logic [15:0] v;
    do_reset();
    prog = 1'b1;
    tick();
    store_word(mk(3'd3, 2'd1, 2'd0, 16'h0005));
    store_word(mk(3'd7, 2'd0, 2'd0, 16'hFFF9));
    n_vec++;
    if (prog_len !== 5'd2) begin n_err++; $display("FAIL ej_len got %0d exp 2", prog_len); end
    prog = 1'b0;
    tick();
    tick(3);
    n_vec++;
    if (err_op !== 1'b1 || pc !== 4'd1) begin
      n_err++; $display("FAIL ej_err got err=%b pc=%0d exp 1 1", err_op, pc);
    end
    tick(3);
    n_vec++;
    if (state !== 3'd5 || pc !== 4'd9 || halted !== 1'b1) begin
      n_err++;
      $display("FAIL ej_halt got state=%0d pc=%0d halted=%b exp 5 9 1", state, pc, halted);
    end
    get_reg(2'd1, v);
    n_vec++;
    if (v !== 16'h0000) begin n_err++; $display("FAIL ej_R1 got %h exp 0000", v); end
  endtask

  task automatic test_wrap();
    logic [15:0] v;
    do_reset();
    prog = 1'b1;
    tick();
    store_word(mk(3'd0, 2'd3, 2'd3, 16'hFFFF));
    store_word(mk(3'd0, 2'd3, 2'd3, 16'h0001));
    prog = 1'b0;
    tick();
    tick(3);
    get_reg(2'd3, v);
    n_vec++;
    if (v !== 16'hFFFF) begin n_err++; $display("FAIL wrap_R3_first got %h exp FFFF", v); end
    tick(3);
    get_reg(2'd3, v);
    n_vec++;
    if (v !== 16'h0000 || state !== 3'd5 || err_op !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_R3 got R3=%h state=%0d err=%b exp 0000 5 0", v, state, err_op);
    end
  endtask

  task automatic test_reset_mid_exec();
    logic [15:0] v;
    do_reset();
    prog = 1'b1;
    tick();
    store_word(mk(3'd5, 2'd0, 2'd0, 16'h0000));
    store_word(mk(3'd0, 2'd1, 2'd0, 16'h0007));
    prog = 1'b0;
    tick();
    tick(3);
    n_vec++;
    if (err_op !== 1'b1) begin n_err++; $display("FAIL rme_err_set got %b exp 1", err_op); end
    tick(2);
    n_vec++;
    if (state !== 3'd4) begin n_err++; $display("FAIL rme_in_exec got %0d exp 4", state); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++;
    if (state !== 3'd0 || pc !== 4'd0 || prog_len !== 5'd0) begin
      n_err++;
      $display("FAIL rme_state got state=%0d pc=%0d len=%0d exp 0 0 0", state, pc, prog_len);
    end
    n_vec++;
    if ({halted, load_full, err_op, bus.imem_we} !== 4'b0000) begin
      n_err++;
      $display("FAIL rme_flags got %b exp 0000", {halted, load_full, err_op, bus.imem_we});
    end
    tick(3);
    get_reg(2'd1, v);
    n_vec++;
    if (v !== 16'h0000 || state !== 3'd0) begin
      n_err++; $display("FAIL rme_R1 got R1=%h state=%0d exp 0000 0", v, state);
    end
  endtask

  initial begin
    reset     = 1'b1;
    prog      = 1'b0;
    store_clk = 1'b0;
    inst      = '0;
    reg_sel   = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_load_run();
    test_store_hold();
    test_jump_loop();
    test_load_full();
    test_reset();
    test_err_jump();
    test_wrap();
    test_reset_mid_exec();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
